// File: rtl/btn_cond_pkg.sv
// ============================================================================
// Package: btn_cond_pkg
// Purpose: Shared types, default timing constants and small elaboration-time
//          helpers for the push-button conditioner (btn_conditioner and its
//          per-channel btn_debounce_ch).
// Contents:
//   btn_state_t     per-channel debounce state
//   DB_10MS_100MHZ  default debounce length (10 ms at 100 MHz)
//   RPT_DELAY_DEF   default press-to-first-repeat delay (0.5 s)
//   RPT_RATE_DEF    default repeat period (0.1 s)
//   max_int         larger of two integers
//   cnt_width       counter width for a modulus, never below 1 bit
// ============================================================================
package btn_cond_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } btn_state_t;

    localparam int DB_10MS_100MHZ = 1_000_000;
    localparam int RPT_DELAY_DEF  = 50_000_000;
    localparam int RPT_RATE_DEF   = 10_000_000;

    function automatic int max_int(input int a, input int b);
        int r;
        if (a > b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

    // A counter that only ever holds 0..n-1 needs $clog2(n) bits; keep at
    // least one bit so degenerate moduli still give a legal vector.
    function automatic int cnt_width(input int n);
        int r;
        r = $clog2(n);
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage : btn_cond_pkg

// File: rtl/btn_debounce_ch.sv
// ============================================================================
// Module: btn_debounce_ch
// Purpose: One button channel: two-flop synchroniser, four-state debounce FSM,
//          stability counter and auto-repeat counter. All outputs registered.
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous reset, active-low
//   btn_raw      in   asynchronous raw button, 1 = pressed
//   btn_level    out  debounced level
//   btn_press    out  one-cycle strobe on debounced 0->1
//   btn_release  out  one-cycle strobe on debounced 1->0
//   btn_rpt      out  one-cycle auto-repeat strobe while held
// ============================================================================
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_10MS_100MHZ,
    parameter bit RPT_EN    = 1'b1,
    parameter int RPT_DELAY = RPT_DELAY_DEF,
    parameter int RPT_RATE  = RPT_RATE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_rpt
);

    localparam int CNT_W  = cnt_width(DB_CYCLES);
    localparam int RCNT_W = cnt_width(max_int(RPT_DELAY, RPT_RATE));

    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_ZERO  = {RCNT_W{1'b0}};
    localparam logic [RCNT_W-1:0] RCNT_ONE   = RCNT_W'(1);
    localparam logic [RCNT_W-1:0] RCNT_DLAST = RCNT_W'(RPT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RCNT_RLAST = RCNT_W'(RPT_RATE - 1);

    logic              sync1_r;
    logic              sync2_r;
    btn_state_t        state_r;
    btn_state_t        state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [RCNT_W-1:0] rcnt_r;
    logic [RCNT_W-1:0] rcnt_s;
    logic              first_r;
    logic              first_s;
    logic              level_r;
    logic              level_s;
    logic              press_r;
    logic              press_s;
    logic              release_r;
    logic              release_s;
    logic              rpt_r;
    logic              rpt_s;

    // Two-flop synchroniser; only sync2_r is used by the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Next-state logic for the debounce FSM, stability counter and repeat timer.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rcnt_s    = rcnt_r;
        first_s   = first_r;
        level_s   = level_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        rpt_s     = 1'b0;
        case (state_r)
            S_LOW: begin
                if (sync2_r) begin
                    state_s = S_RISE;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            S_RISE: begin
                if (!sync2_r) begin
                    // Bounce: fall back without any strobe.
                    state_s = S_LOW;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = S_HIGH;
                    cnt_s   = CNT_ZERO;
                    level_s = 1'b1;
                    press_s = 1'b1;
                    rcnt_s  = RCNT_ZERO;
                    first_s = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync2_r) begin
                    state_s = S_FALL;
                    cnt_s   = CNT_ONE;
                end else if (RPT_EN) begin
                    // First repeat waits the long delay, later ones the short rate.
                    if (first_r && (rcnt_r == RCNT_DLAST)) begin
                        rpt_s   = 1'b1;
                        rcnt_s  = RCNT_ZERO;
                        first_s = 1'b0;
                    end else if (!first_r && (rcnt_r == RCNT_RLAST)) begin
                        rpt_s   = 1'b1;
                        rcnt_s  = RCNT_ZERO;
                    end else begin
                        rcnt_s  = rcnt_r + RCNT_ONE;
                    end
                end else begin
                    rcnt_s = rcnt_r;
                end
            end
            S_FALL: begin
                if (sync2_r) begin
                    // Glitch while falling: resume the repeat timer where it stopped.
                    state_s = S_HIGH;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = S_LOW;
                    cnt_s     = CNT_ZERO;
                    level_s   = 1'b0;
                    release_s = 1'b1;
                end else begin
                    cnt_s     = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = S_LOW;
                cnt_s   = CNT_ZERO;
                rcnt_s  = RCNT_ZERO;
                first_s = 1'b0;
                level_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_LOW;
            cnt_r     <= CNT_ZERO;
            rcnt_r    <= RCNT_ZERO;
            first_r   <= 1'b0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            rpt_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rcnt_r    <= rcnt_s;
            first_r   <= first_s;
            level_r   <= level_s;
            press_r   <= press_s;
            release_r <= release_s;
            rpt_r     <= rpt_s;
        end
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;
    assign btn_rpt     = rpt_r;

endmodule : btn_debounce_ch

// File: rtl/btn_conditioner.sv
// ============================================================================
// Module: btn_conditioner
// Purpose: Push-button front end. N_BTN fully independent channels, each
//          synchronised and debounced, producing a clean level plus press,
//          release and optional auto-repeat strobes.
// Ports:
//   clk          in   1      system clock
//   rst_n        in   1      synchronous reset, active-low
//   btn_raw      in   N_BTN  asynchronous raw buttons, 1 = pressed
//   btn_level    out  N_BTN  debounced level
//   btn_press    out  N_BTN  one-cycle strobe on debounced 0->1
//   btn_release  out  N_BTN  one-cycle strobe on debounced 1->0
//   btn_rpt      out  N_BTN  one-cycle auto-repeat strobe while held
// ============================================================================
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int N_BTN     = 5,
    parameter int DB_CYCLES = DB_10MS_100MHZ,
    parameter bit RPT_EN    = 1'b1,
    parameter int RPT_DELAY = RPT_DELAY_DEF,
    parameter int RPT_RATE  = RPT_RATE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_rpt
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES (DB_CYCLES),
            .RPT_EN    (RPT_EN),
            .RPT_DELAY (RPT_DELAY),
            .RPT_RATE  (RPT_RATE)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_raw     (btn_raw[g]),
            .btn_level   (btn_level[g]),
            .btn_press   (btn_press[g]),
            .btn_release (btn_release[g]),
            .btn_rpt     (btn_rpt[g])
        );
    end

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner. The reference model works on sample
// run lengths: a channel's level flips once DB consecutive synchronised
// samples disagree with it, and repeats fire after RD, RD+RR, RD+2RR ...
// "held" cycles counted since the press.
module tb_btn_conditioner;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    typedef struct packed {
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] rpt;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_rpt;
    logic [NB-1:0] n_level, n_press, n_release, n_rpt;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    bit   started;
    bit   done;
    bit   saw_simul;

    // Model state
    logic m_s1 [NB];
    logic m_s2 [NB];
    logic m_lvl[NB];
    int   m_run[NB];
    int   m_act[NB];

    btn_conditioner #(
        .N_BTN(NB), .DB_CYCLES(DB), .RPT_EN(1'b1), .RPT_DELAY(RD), .RPT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_rpt(btn_rpt)
    );

    btn_conditioner #(
        .N_BTN(NB), .DB_CYCLES(DB), .RPT_EN(1'b0), .RPT_DELAY(RD), .RPT_RATE(RR)
    ) dut_norpt (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(n_level), .btn_press(n_press),
        .btn_release(n_release), .btn_rpt(n_rpt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Predict the outputs after the next rising edge given the inputs sampled there.
    task automatic model_edge(input logic rn, input logic [NB-1:0] raw);
        exp_t e;
        logic s;
        logic lvl_old;
        int   run_old;
        e = '0;
        for (int i = 0; i < NB; i++) begin
            if (!rn) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_lvl[i] = 1'b0;
                m_run[i] = 0;   m_act[i] = 0;
            end else begin
                s       = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
                lvl_old = m_lvl[i];
                run_old = m_run[i];
                if (s != lvl_old) begin
                    m_run[i] = run_old + 1;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = s;
                        m_run[i] = 0;
                        if (s) begin
                            e.press[i] = 1'b1;
                            m_act[i]   = 0;
                        end else begin
                            e.rel[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                    // Held and not mid-fall: one more cycle of hold time.
                    if (lvl_old && run_old == 0) begin
                        m_act[i]++;
                        if (m_act[i] == RD || (m_act[i] > RD && (m_act[i] - RD) % RR == 0))
                            e.rpt[i] = 1'b1;
                    end
                end
            end
            e.level[i] = m_lvl[i];
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rn, input logic [NB-1:0] raw);
        @(negedge clk);
        rst_n   = rn;
        btn_raw = raw;
        model_edge(rn, raw);
        started = 1'b1;
    endtask

    task automatic hold(input logic rn, input logic [NB-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(rn, raw);
    endtask

    // Monitor: compare the DUT against the oldest prediction after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started && !done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL queue_empty at %0t: got no prediction expected one", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("level",   btn_level,   e.level);
                    chk("press",   btn_press,   e.press);
                    chk("release", btn_release, e.rel);
                    chk("rpt",     btn_rpt,     e.rpt);
                    chk("norpt_level", n_level, e.level);
                    chk("norpt_rpt",   n_rpt,   {NB{1'b0}});
                    if (btn_press == 5'b10001) saw_simul = 1'b1;
                end
            end
        end
    end

    initial begin
        int            hcnt[NB];
        logic [NB-1:0] r;
        logic          rn;
        checks = 0; errors = 0; started = 1'b0; done = 1'b0; saw_simul = 1'b0;
        rst_n = 1'b0; btn_raw = '0;

        hold(1'b0, 5'b00000, 3);                       // reset
        hold(1'b1, 5'b00000, 2);
        hold(1'b1, 5'b00010, 15);                      // clean press on [1]
        hold(1'b1, 5'b00000, 2);                       // release with a glitch
        step(1'b1, 5'b00010);
        hold(1'b1, 5'b00000, 10);
        hold(1'b1, 5'b00100, 2);                       // bounce on [2]
        hold(1'b1, 5'b00000, 2);
        hold(1'b1, 5'b00100, 2);
        hold(1'b1, 5'b00000, 2);
        hold(1'b1, 5'b00100, 12);
        hold(1'b1, 5'b00000, 10);
        hold(1'b1, 5'b01000, 60);                      // auto-repeat on [3]
        hold(1'b1, 5'b00000, 30);
        hold(1'b1, 5'b00001, 2);                       // reset mid-debounce on [0]
        step(1'b0, 5'b00001);
        hold(1'b1, 5'b00001, 12);
        hold(1'b1, 5'b00000, 10);
        hold(1'b1, 5'b10001, 12);                      // simultaneous [0] and [4]
        hold(1'b1, 5'b00000, 10);

        // Random phase: mixes bounces, long holds and rare resets.
        r = '0;
        for (int i = 0; i < NB; i++) hcnt[i] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NB; i++) begin
                if (hcnt[i] == 0) begin
                    r[i] = ~r[i];
                    hcnt[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 50)
                                                          : $urandom_range(1, 6);
                end else begin
                    hcnt[i]--;
                end
            end
            rn = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            step(rn, r);
        end
        hold(1'b1, 5'b00000, 10);

        @(posedge clk);
        #2;
        done = 1'b1;
        checks++;
        if (!saw_simul) begin
            errors++;
            $display("FAIL simultaneous_press: got no 10001 press vector expected one");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_btn_conditioner
